// File: rtl/argmax_out.sv
// argmax_out: sequential arg-max over the nine output-layer sums z3_1..z3_9.
// A vector is captured in IDLE, scanned one element per clock in SCAN, and the
// winning class index and value are held in DONE until the consumer takes them.
// Ties keep the lowest index (strict greater-than replaces the running best).
// Optional feature macro: ARGMAX_MARGIN_EN adds second-best tracking and the
// out_margin port (best minus second-best, DW+1 bits, never negative).
module argmax_out #(
    parameter int DW = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] z3_1,
    input  logic signed [DW-1:0] z3_2,
    input  logic signed [DW-1:0] z3_3,
    input  logic signed [DW-1:0] z3_4,
    input  logic signed [DW-1:0] z3_5,
    input  logic signed [DW-1:0] z3_6,
    input  logic signed [DW-1:0] z3_7,
    input  logic signed [DW-1:0] z3_8,
    input  logic signed [DW-1:0] z3_9,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_class,
`ifdef ARGMAX_MARGIN_EN
    output logic [DW:0]          out_margin,
`endif
    output logic signed [DW-1:0] out_max
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    state_t                 state_q;
    logic [3:0]             idx_q;
    logic signed [DW-1:0]   vec_q [9];
    logic signed [DW-1:0]   best_val_q, best_val_d;
    logic [3:0]             best_idx_q, best_idx_d;
    logic signed [DW-1:0]   cand;
    logic                   accept;
    logic                   out_valid_q;
    logic [3:0]             out_class_q;
    logic signed [DW-1:0]   out_max_q;
`ifdef ARGMAX_MARGIN_EN
    logic signed [DW-1:0]   second_q, second_d;
    logic [DW:0]            out_margin_q;

    // Difference of two signed DW-bit values widened by one bit so the
    // extreme case (max positive minus max negative) cannot overflow.
    function automatic logic [DW:0] margin_f(input logic signed [DW-1:0] a,
                                             input logic signed [DW-1:0] b);
        logic signed [DW:0] diff;
        diff = {a[DW-1], a} - {b[DW-1], b};
        return diff;
    endfunction
`endif

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_max   = out_max_q;
`ifdef ARGMAX_MARGIN_EN
    assign out_margin = out_margin_q;
`endif

    // Select the captured element addressed by the scan index.
    always_comb begin
        cand = vec_q[0];
        case (idx_q)
            4'd1:    cand = vec_q[1];
            4'd2:    cand = vec_q[2];
            4'd3:    cand = vec_q[3];
            4'd4:    cand = vec_q[4];
            4'd5:    cand = vec_q[5];
            4'd6:    cand = vec_q[6];
            4'd7:    cand = vec_q[7];
            4'd8:    cand = vec_q[8];
            default: cand = vec_q[0];
        endcase
    end

    // Running best (and second-best) after comparing the current element.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (cand > best_val_q) begin
            best_val_d = cand;
            best_idx_d = idx_q;
        end
`ifdef ARGMAX_MARGIN_EN
        second_d = second_q;
        if (cand > best_val_q) begin
            second_d = best_val_q;
        end else if (cand > second_q) begin
            second_d = cand;
        end
`endif
    end

    // Datapath registers: vector capture on accept, running best during SCAN.
    always_ff @(posedge clk) begin
        if (accept) begin
            vec_q[0]   <= z3_1;
            vec_q[1]   <= z3_2;
            vec_q[2]   <= z3_3;
            vec_q[3]   <= z3_4;
            vec_q[4]   <= z3_5;
            vec_q[5]   <= z3_6;
            vec_q[6]   <= z3_7;
            vec_q[7]   <= z3_8;
            vec_q[8]   <= z3_9;
            best_val_q <= z3_1;
            best_idx_q <= 4'd0;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= MIN_VAL;
`endif
        end else if (state_q == SCAN) begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= second_d;
`endif
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            out_valid_q  <= 1'b0;
            out_class_q  <= 4'd0;
            out_max_q    <= '0;
`ifdef ARGMAX_MARGIN_EN
            out_margin_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= SCAN;
                        idx_q   <= 4'd1;
                    end
                end
                SCAN: begin
                    if (idx_q == 4'd8) begin
                        out_class_q  <= best_idx_d;
                        out_max_q    <= best_val_d;
`ifdef ARGMAX_MARGIN_EN
                        out_margin_q <= margin_f(best_val_d, second_d);
`endif
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // MIN_VAL is only referenced by the margin logic.
`ifndef ARGMAX_MARGIN_EN
    logic unused_min;
    assign unused_min = ^MIN_VAL;
`endif

endmodule

// File: tb/tb_argmax_out.sv
// Testbench for argmax_out: directed vectors, expected results queued at
// accept time and checked by an independent output monitor.
module tb_argmax_out;

    localparam int DW = 20;

    typedef logic signed [DW-1:0] vec_t [9];

    typedef struct {
        logic [3:0]          cls;
        logic signed [DW-1:0] mx;
        logic [DW:0]         mg;
        int                  acc;
    } exp_t;

    localparam vec_t V1 = '{20'sh01000, 20'sh09000, 20'sh02000, -20'sh03000, 20'sh00000,
                            20'sh08000, 20'sh0A000, 20'sh05000, 20'sh09000};
    localparam vec_t V2 = '{-20'sh01000, -20'sh02000, -20'sh05000, -20'sh00800, -20'sh10000,
                            -20'sh01000, -20'sh03000, -20'sh01800, -20'sh04000};
    localparam vec_t V3 = '{20'sh01000, 20'sh02000, 20'sh08000, 20'sh03000, 20'sh04000,
                            20'sh05000, 20'sh06000, 20'sh08000, 20'sh07000};
    localparam vec_t V4 = '{20'sh00100, 20'sh00200, 20'sh00300, 20'sh00400, 20'sh00500,
                            20'sh00600, 20'sh00700, 20'sh00800, 20'sh00900};
    localparam vec_t V5 = '{20'sh80000, 20'sh80000, 20'sh7FFFF, 20'sh80000, 20'sh80000,
                            20'sh80000, 20'sh80000, 20'sh80000, 20'sh80000};
    localparam vec_t V6 = '{20'sh08000, 20'sh18000, 20'sh00000, 20'sh00000, 20'sh00000,
                            20'sh00000, 20'sh00000, 20'sh00000, 20'sh00000};

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] z [9];
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_class;
    logic signed [DW-1:0] out_max;
`ifdef ARGMAX_MARGIN_EN
    logic [DW:0]          out_margin;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;
    exp_t sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    argmax_out #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z3_1      (z[0]),
        .z3_2      (z[1]),
        .z3_3      (z[2]),
        .z3_4      (z[3]),
        .z3_5      (z[4]),
        .z3_6      (z[5]),
        .z3_7      (z[6]),
        .z3_8      (z[7]),
        .z3_9      (z[8]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
`ifdef ARGMAX_MARGIN_EN
        .out_margin(out_margin),
`endif
        .out_max   (out_max)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic set_vec(input vec_t v);
        for (int i = 0; i < 9; i++) z[i] = v[i];
    endtask

    // Called at posedge+1; offers one vector and records the accept cycle.
    task automatic send(input vec_t v, input logic [3:0] c, input logic signed [DW-1:0] m,
                        input logic [DW:0] mg, input bit push);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) fail_now("send_wait_ready");
        set_vec(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.cls = c; e.mx = m; e.mg = mg; e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0 || out_valid) fail_now("drain");
    endtask

    // Output monitor: latency on rising out_valid, payload on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                if (sbq.size() == 0) fail_now("unexpected_out_valid");
                else chk("latency", cyc - sbq[0].acc, 32'd8);
            end
            if (out_valid && out_ready && sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("out_class", {28'd0, out_class}, {28'd0, e.cls});
                chk("out_max", 32'(out_max), 32'(e.mx));
`ifdef ARGMAX_MARGIN_EN
                chk("out_margin", 32'(out_margin), 32'(e.mg));
`endif
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_vec(V4);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_class", {28'd0, out_class}, 32'd0);
        chk("rst_out_max", 32'(out_max), 32'd0);
`ifdef ARGMAX_MARGIN_EN
        chk("rst_out_margin", 32'(out_margin), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Positive, all-negative, tie, and signed extremes.
        send(V1, 4'd6, 20'sh0A000, 21'h001000, 1'b1);
        drain();
        send(V2, 4'd3, -20'sh00800, 21'h000800, 1'b1);
        drain();
        send(V3, 4'd2, 20'sh08000, 21'h000000, 1'b1);
        drain();
        send(V5, 4'd2, 20'sh7FFFF, 21'h0FFFFF, 1'b1);
        drain();
        send(V6, 4'd1, 20'sh18000, 21'h010000, 1'b1);
        drain();
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Backpressure with in_valid pulsing while the result is held.
        out_ready = 1'b0;
        send(V4, 4'd8, 20'sh00900, 21'h000100, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (!out_valid) fail_now("bp_wait_valid");
        end
        set_vec(V1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_class", {28'd0, out_class}, 32'd8);
            chk("bp_out_max", 32'(out_max), 32'h00000900);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        repeat (12) begin
            @(posedge clk); #1;
        end
        chk("bp_no_capture", {31'd0, out_valid}, 32'd0);
        chk("bp_queue_empty", sbq.size(), 32'd0);

        // Reset during the 4th SCAN cycle discards the in-flight vector.
        send(V1, 4'd6, 20'sh0A000, 21'h001000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_class", {28'd0, out_class}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(V2, 4'd3, -20'sh00800, 21'h000800, 1'b1);
        drain();
        repeat (12) begin
            @(posedge clk); #1;
        end
        chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
